rx_os_deser: RTL and testbench

//  Parametrised successor to the fixed x8 fibre receiver. It synchronises the raw optical input
//  and recovers bit timing by oversampling at OVERSAMPLE x the bit rate. It deserialises bits into

---
 rtl/rx_os_deser.sv | 133 +++++++++++++
 tb/tb_rx_os_deser.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rx_os_deser.sv
// Oversampling serial receiver: synchronises d_in, recovers bit phase from edges, deserialises
// words, frames on SYNC_WORD and drops back to hunting when a run-length violation is seen.
module rx_os_deser #(
  parameter int                OVERSAMPLE  = 8,
  parameter int                WORD_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WORD_W-1:0] SYNC_WORD   = 8'hA5,
  parameter bit                MSB_FIRST   = 1'b1,
  parameter int                MAX_RUN     = 16,
  parameter int                CNT_W       = 16
) (
  input  logic              clk_sample,
  input  logic              rst_n,
  input  logic              d_in,
  output logic              clk_recovered,
  output logic [WORD_W-1:0] d_out,
  output logic              d_out_valid,
  output logic              reframe,
  output logic              locked,
  output logic [CNT_W-1:0]  reframe_count
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WORD_W);
  localparam int RW = $clog2(MAX_RUN + 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_RUN);
  localparam logic [RW-1:0] RUN_HIT  = RW'(MAX_RUN - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                ds, ds_prev, edge_det, strobe, run_hit;
  logic [PW-1:0]       phase;
  logic [RW-1:0]       run_cnt;
  logic [BW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [WORD_W-1:0]   sh, sh_nxt;
  logic                vld_nxt, rf_nxt, load_word;

  assign ds            = sync_q[SYNC_STAGES-1];
  assign edge_det      = ds ^ ds_prev;
  assign strobe        = (phase == PH_MID);
  assign clk_recovered = (phase >= PH_MID);
  assign locked        = (state == LOCKED);
  // The transition that resets the run counter also cancels a violation on the same strobe.
  assign run_hit       = strobe && !edge_det && (run_cnt >= RUN_HIT);

  always_comb begin
    sh_nxt = sh;
    if (strobe) begin
      if (MSB_FIRST) sh_nxt = {sh[WORD_W-2:0], ds};
      else           sh_nxt = {ds, sh[WORD_W-1:1]};
    end
  end

  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      ds_prev <= 1'b0;
      phase   <= '0;
      run_cnt <= '0;
      sh      <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_in};
      ds_prev <= ds;
      sh      <= sh_nxt;
      // An edge marks phase 0, so the counter resumes at 1 on the following cycle.
      if (edge_det)              phase <= PW'(1);
      else if (phase == PH_LAST) phase <= '0;
      else                       phase <= phase + PW'(1);
      if (edge_det)                       run_cnt <= '0;
      else if (strobe && run_cnt != RUN_MAX) run_cnt <= run_cnt + RW'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    vld_nxt     = 1'b0;
    rf_nxt      = 1'b0;
    load_word   = 1'b0;
    if (strobe) begin
      unique case (state)
        HUNT: begin
          if (sh_nxt == SYNC_WORD) begin
            state_nxt   = LOCKED;
            bit_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (run_hit) begin
            state_nxt   = HUNT;
            rf_nxt      = 1'b1;
            bit_cnt_nxt = '0;
          end else if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            // A sync word seen in-stream is a realignment marker, not data.
            if (sh_nxt != SYNC_WORD) begin
              vld_nxt   = 1'b1;
              load_word = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      bit_cnt       <= '0;
      d_out         <= '0;
      d_out_valid   <= 1'b0;
      reframe       <= 1'b0;
      reframe_count <= '0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      d_out_valid <= vld_nxt;
      reframe     <= rf_nxt;
      if (load_word) d_out <= sh_nxt;
      if (rf_nxt && reframe_count != {CNT_W{1'b1}})
        reframe_count <= reframe_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rx_os_deser.sv
// Scoreboarded bench: default x8 instance plus a 10-bit LSB-first x4 instance.
module tb_rx_os_deser;

  logic        clk = 1'b0;
  logic        rst_n, rst1_n, d_in, d_in1;
  logic        crec0, dv0, rf0, lk0;
  logic [7:0]  dout0;
  logic [15:0] rcnt0;
  logic        crec1, dv1, rf1, lk1;
  logic [9:0]  dout1;
  logic [15:0] rcnt1;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int rf_seen = 0;
  int drift_k = 0;
  logic [7:0] q0[$];
  logic [9:0] q1[$];
  int vtimes[$];
  logic prev_dv0 = 1'b0, prev_rf0 = 1'b0, prev_dv1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  rx_os_deser u0 (
    .clk_sample(clk), .rst_n(rst_n), .d_in(d_in), .clk_recovered(crec0),
    .d_out(dout0), .d_out_valid(dv0), .reframe(rf0), .locked(lk0), .reframe_count(rcnt0)
  );

  rx_os_deser #(.OVERSAMPLE(4), .WORD_W(10), .SYNC_WORD(10'h2B5), .MSB_FIRST(1'b0)) u1 (
    .clk_sample(clk), .rst_n(rst1_n), .d_in(d_in1), .clk_recovered(crec1),
    .d_out(dout1), .d_out_valid(dv1), .reframe(rf1), .locked(lk1), .reframe_count(rcnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the scoreboard whenever an instance presents a word.
  always @(negedge clk) begin
    if (dv0) begin
      if (q0.size() == 0) chk("u0 unexpected word", {24'd0, dout0}, 32'hFFFF_FFFF);
      else                chk("u0 word", {24'd0, dout0}, {24'd0, q0.pop_front()});
      chk("u0 valid width", {31'd0, prev_dv0}, 32'd0);
      vtimes.push_back(cyc);
    end
    if (rf0) begin
      rf_seen++;
      chk("u0 valid on reframe", {31'd0, dv0}, 32'd0);
      chk("u0 reframe width", {31'd0, prev_rf0}, 32'd0);
    end
    if (dv1) begin
      if (q1.size() == 0) chk("u1 unexpected word", {22'd0, dout1}, 32'hFFFF_FFFF);
      else                chk("u1 word", {22'd0, dout1}, {22'd0, q1.pop_front()});
      chk("u1 valid width", {31'd0, prev_dv1}, 32'd0);
    end
    prev_dv0 = dv0;
    prev_rf0 = rf0;
    prev_dv1 = dv1;
  end

  task automatic send_bit0(input logic b, input int dur);
    d_in = b;
    repeat (dur) @(negedge clk);
  endtask

  // Drifted bits alternate 9,7,7,9 samples so accumulated timing error stays within one sample.
  task automatic send_word0(input logic [7:0] w, input bit drift, input bit push);
    int d;
    if (push) q0.push_back(w);
    for (int i = 7; i >= 0; i--) begin
      d = 8;
      if (drift) begin
        case (drift_k % 4)
          0: d = 9;
          1: d = 7;
          2: d = 7;
          default: d = 9;
        endcase
        drift_k++;
      end
      send_bit0(w[i], d);
    end
  endtask

  task automatic send_word1(input logic [9:0] w, input bit push);
    if (push) q1.push_back(w);
    for (int i = 0; i < 10; i++) begin
      d_in1 = w[i];
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0; d_in = 1'b0; d_in1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset d_out", {24'd0, dout0}, 32'd0);
    chk("reset valid", {31'd0, dv0}, 32'd0);
    chk("reset reframe", {31'd0, rf0}, 32'd0);
    chk("reset locked", {31'd0, lk0}, 32'd0);
    chk("reset count", {16'd0, rcnt0}, 32'd0);
    chk("reset clk_recovered", {31'd0, crec0}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("hunt idle locked", {31'd0, lk0}, 32'd0);

    // Lock, two data words, in-stream marker, then a word that must still be aligned.
    send_word0(8'hA5, 1'b0, 1'b0);
    send_word0(8'h3C, 1'b0, 1'b1);
    chk("locked after sync", {31'd0, lk0}, 32'd1);
    send_word0(8'h96, 1'b0, 1'b1);
    send_word0(8'hA5, 1'b0, 1'b0);
    send_word0(8'h5A, 1'b0, 1'b1);
    // 40 drifted bits.
    send_word0(8'h12, 1'b1, 1'b1);
    send_word0(8'h34, 1'b1, 1'b1);
    send_word0(8'hC3, 1'b1, 1'b1);
    send_word0(8'h7E, 1'b1, 1'b1);
    send_word0(8'hE1, 1'b1, 1'b1);
    // 17 zero bit times: first zero word is data, the 16th zero bit breaks lock.
    send_word0(8'hFF, 1'b0, 1'b1);
    send_word0(8'h00, 1'b0, 1'b1);
    send_bit0(1'b0, 72);
    repeat (10) @(negedge clk);
    chk("reframe strobes", rf_seen, 32'd1);
    chk("locked after run", {31'd0, lk0}, 32'd0);
    chk("reframe_count", {16'd0, rcnt0}, 32'd1);
    chk("no drift reframe before run", {31'd0, lk0 | rf0}, 32'd0);

    // Relock, one word, then reset in the middle of the next word.
    send_word0(8'hA5, 1'b0, 1'b0);
    send_word0(8'h3C, 1'b0, 1'b1);
    chk("relocked", {31'd0, lk0}, 32'd1);
    send_bit0(1'b1, 8); send_bit0(1'b0, 8); send_bit0(1'b0, 8); send_bit0(1'b1, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset d_out", {24'd0, dout0}, 32'd0);
    chk("mid reset locked", {31'd0, lk0}, 32'd0);
    chk("mid reset count", {16'd0, rcnt0}, 32'd0);
    chk("mid reset valid", {31'd0, dv0 | rf0}, 32'd0);
    d_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post reset hunt", {31'd0, lk0}, 32'd0);
    send_word0(8'hA5, 1'b0, 1'b0);
    send_word0(8'h96, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    rst_n = 1'b0;

    // 10-bit LSB-first x4 instance.
    rst1_n = 1'b1;
    repeat (20) @(negedge clk);
    send_word1(10'h2B5, 1'b0);
    send_word1(10'h155, 1'b1);
    repeat (12) @(negedge clk);
    chk("u1 locked", {31'd0, lk1}, 32'd1);

    chk("valid count u0", vtimes.size(), 32'd12);
    if (vtimes.size() >= 2) chk("valid spacing", vtimes[1] - vtimes[0], 32'd64);
    else                    chk("valid spacing", 32'd0, 32'd64);
    chk("u0 words outstanding", q0.size(), 32'd0);
    chk("u1 words outstanding", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
